// File: rtl/step_pulse_gen.sv
// Synthetic step source: evenly spaced one-cycle pulses at a mode-selected steps/s, or a 9-second hybrid profile.
// All outputs are registered and line up with the internal counters; no backpressure, start is the only enable.
module step_pulse_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       stepPulse,
  output logic       secTick,
  output logic [3:0] hybridSec,
  output logic [7:0] rate,
  output logic       active,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(CLK_HZ - 1);

  function automatic logic [7:0] fixed_rate(input logic [1:0] m);
    case (m)
      2'b00:   fixed_rate = 8'd32;
      2'b01:   fixed_rate = 8'd64;
      2'b10:   fixed_rate = 8'd128;
      default: fixed_rate = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] hyb_rate(input logic [3:0] s);
    case (s)
      4'd1:    hyb_rate = 8'd20;
      4'd2:    hyb_rate = 8'd33;
      4'd3:    hyb_rate = 8'd66;
      4'd4:    hyb_rate = 8'd27;
      4'd5:    hyb_rate = 8'd70;
      4'd6:    hyb_rate = 8'd30;
      4'd7:    hyb_rate = 8'd19;
      4'd8:    hyb_rate = 8'd30;
      4'd9:    hyb_rate = 8'd33;
      default: hyb_rate = 8'd0;
    endcase
  endfunction

  // Only a handful of rates exist, so the divide folds to constants.
  function automatic logic [CNT_W-1:0] interval_of(input logic [7:0] r);
    case (r)
      8'd19:   interval_of = CNT_W'(CLK_HZ / 19);
      8'd20:   interval_of = CNT_W'(CLK_HZ / 20);
      8'd27:   interval_of = CNT_W'(CLK_HZ / 27);
      8'd30:   interval_of = CNT_W'(CLK_HZ / 30);
      8'd32:   interval_of = CNT_W'(CLK_HZ / 32);
      8'd33:   interval_of = CNT_W'(CLK_HZ / 33);
      8'd64:   interval_of = CNT_W'(CLK_HZ / 64);
      8'd66:   interval_of = CNT_W'(CLK_HZ / 66);
      8'd70:   interval_of = CNT_W'(CLK_HZ / 70);
      8'd128:  interval_of = CNT_W'(CLK_HZ / 128);
      default: interval_of = '1;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] int_cnt_q, int_cnt_d;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;
  logic [7:0]       rate_q, rate_d;
  logic [3:0]       hyb_q, hyb_d;
  logic             step_q, step_d;
  logic             tick_q, tick_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    sec_cnt_d   = sec_cnt_q;
    int_cnt_d   = int_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    rate_d      = rate_q;
    hyb_d       = hyb_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          sec_cnt_d   = '0;
          int_cnt_d   = '0;
          pulse_cnt_d = '0;
          if (mode == 2'b11) begin
            hyb_d  = 4'd1;
            rate_d = hyb_rate(4'd1);
          end else begin
            hyb_d  = 4'd0;
            rate_d = fixed_rate(mode);
          end
        end
      end

      RUN: begin
        if (!start) begin
          state_d     = IDLE;
          sec_cnt_d   = '0;
          int_cnt_d   = '0;
          pulse_cnt_d = '0;
          rate_d      = '0;
          hyb_d       = '0;
        end else if (sec_cnt_q == SEC_LAST) begin
          sec_cnt_d   = '0;
          int_cnt_d   = '0;
          pulse_cnt_d = '0;
          if (mode == 2'b11) begin
            if (hyb_q == 4'd9) begin
              state_d = DONE;
              rate_d  = '0;
            end else if (hyb_q == 4'd0) begin
              hyb_d  = 4'd1;
              rate_d = hyb_rate(4'd1);
            end else begin
              hyb_d  = hyb_q + 4'd1;
              rate_d = hyb_rate(hyb_q + 4'd1);
            end
          end else begin
            hyb_d  = 4'd0;
            rate_d = fixed_rate(mode);
          end
        end else begin
          sec_cnt_d = sec_cnt_q + CNT_W'(1);
          // step_q marks the firing cycle, so the interval restarts right after it.
          if (step_q) begin
            int_cnt_d   = '0;
            pulse_cnt_d = pulse_cnt_q + 8'd1;
          end else begin
            int_cnt_d = int_cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
          hyb_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs look ahead at next state so they coincide with the counters they describe.
    step_d   = (state_d == RUN) && (int_cnt_d == interval_of(rate_d) - CNT_W'(1)) &&
               (pulse_cnt_d < rate_d);
    tick_d   = (state_d == RUN) && (sec_cnt_d == SEC_LAST);
    active_d = (state_d == RUN);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sec_cnt_q   <= '0;
      int_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      rate_q      <= '0;
      hyb_q       <= '0;
      step_q      <= 1'b0;
      tick_q      <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_cnt_q   <= sec_cnt_d;
      int_cnt_q   <= int_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      rate_q      <= rate_d;
      hyb_q       <= hyb_d;
      step_q      <= step_d;
      tick_q      <= tick_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign stepPulse = step_q;
  assign secTick   = tick_q;
  assign hybridSec = hyb_q;
  assign rate      = rate_q;
  assign active    = active_q;
  assign done      = done_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed plan plus randomized mode/start/reset activity against an arithmetic window model.
module tb_step_pulse_gen;

  localparam int CLK_HZ = 1024;
  localparam int CNT_W  = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic       stepPulse;
  logic       secTick;
  logic [3:0] hybridSec;
  logic [7:0] rate;
  logic       active;
  logic       done;

  step_pulse_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .stepPulse(stepPulse), .secTick(secTick), .hybridSec(hybridSec),
    .rate(rate), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int hyb_tab[10] = '{0, 20, 33, 66, 27, 70, 30, 19, 30, 33};

  // Model: which state, which cycle of the window, which rate and hybrid second apply.
  int m_state = 0;  // 0 idle, 1 generating, 2 profile finished
  int m_c     = 0;
  int m_rate  = 0;
  int m_hyb   = 0;

  int win_cnt, first_p, last_p;
  int last_win_cnt, last_win_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pulse();
    int ivl, k;
    if (m_state != 1 || m_rate == 0) return 1'b0;
    ivl = CLK_HZ / m_rate;
    k   = m_c + 1;
    return (k % ivl == 0) && (k / ivl <= m_rate);
  endfunction

  task automatic model_reset();
    m_state = 0; m_c = 0; m_rate = 0; m_hyb = 0;
  endtask

  task automatic model_load_mode(input bit continuing);
    if (mode == 2'b11) begin
      if (continuing && m_hyb == 9) begin
        m_state = 2; m_rate = 0;
      end else begin
        m_hyb  = (continuing && m_hyb != 0) ? m_hyb + 1 : 1;
        m_rate = hyb_tab[m_hyb];
      end
    end else begin
      m_hyb  = 0;
      m_rate = 32 << mode;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_c = 0;
        model_load_mode(1'b0);
      end
    end else if (m_state == 1) begin
      if (!start) model_reset();
      else if (m_c == CLK_HZ - 1) begin
        m_c = 0;
        model_load_mode(1'b1);
      end else m_c++;
    end else begin
      if (!start) model_reset();
    end
  endtask

  task automatic check_outputs();
    chk("stepPulse", stepPulse, exp_pulse());
    chk("secTick", secTick, (m_state == 1 && m_c == CLK_HZ - 1));
    chk("hybridSec", hybridSec, (m_state == 2) ? 9 : m_hyb);
    chk("rate", rate, (m_state == 1) ? m_rate : 0);
    chk("active", active, (m_state == 1));
    chk("done", done, (m_state == 2));
    if (m_state == 1) begin
      if (m_c == 0) begin
        win_cnt = 0; first_p = -1; last_p = -1;
      end
      if (stepPulse === 1'b1) begin
        win_cnt++;
        last_p = m_c;
        if (first_p < 0) first_p = m_c;
      end
      if (m_c == CLK_HZ - 1) begin
        chk("win_pulses", win_cnt, m_rate);
        chk("first_pulse", first_p, CLK_HZ / m_rate - 1);
        last_win_cnt  = win_cnt;
        last_win_last = last_p;
      end
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
    end
  endtask

  // Reset lands between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    model_edge();
    #3 reset = 1'b1;
    #1;
    chk("arst_step", stepPulse, 0);
    chk("arst_tick", secTick, 0);
    chk("arst_hyb", hybridSec, 0);
    chk("arst_rate", rate, 0);
    chk("arst_active", active, 0);
    chk("arst_done", done, 0);
    model_reset();
    @(negedge clk);
    check_outputs();
    cycle(2);
    reset = 1'b0;
  endtask

  int hyb_exp[10] = '{0, 20, 33, 66, 27, 70, 30, 19, 30, 33};

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00;
    win_cnt = 0; first_p = -1; last_p = -1; last_win_cnt = 0; last_win_last = 0;
    cycle(3);
    reset = 1'b0;
    cycle(2);

    // Walk, two windows.
    start = 1'b1; mode = 2'b00;
    cycle(2 * CLK_HZ);
    chk("walk_cnt", last_win_cnt, 32);
    start = 1'b0;
    cycle(2);

    // Run, then jog requested mid-window.
    start = 1'b1; mode = 2'b10;
    cycle(CLK_HZ + 500);
    mode = 2'b01;
    cycle(CLK_HZ - 500);
    chk("run_cnt_after_change", last_win_cnt, 128);
    cycle(CLK_HZ);
    chk("jog_cnt", last_win_cnt, 64);
    start = 1'b0;
    cycle(2);

    // Full hybrid profile, then a window's worth of DONE.
    start = 1'b1; mode = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      cycle(CLK_HZ);
      chk("hyb_cnt", last_win_cnt, hyb_exp[k]);
      if (k == 5) chk("hyb5_last", last_win_last, 979);
    end
    cycle(CLK_HZ);
    chk("done_held", done, 1);
    start = 1'b0;
    cycle(2);

    // Drop start mid-walk, then re-raise.
    start = 1'b1; mode = 2'b00;
    cycle(500);
    start = 1'b0;
    cycle(3);
    start = 1'b1;
    cycle(40);
    chk("restart_first", first_p, 31);

    // Async reset mid-jog, then restart.
    mode = 2'b01;
    cycle(300);
    async_reset();
    cycle(100);
    chk("post_reset_first", first_p, 15);

    // Random mode, start and reset activity.
    for (int s = 0; s < 25; s++) begin
      int len;
      len   = $urandom_range(1, 1500);
      mode  = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) async_reset();
      cycle(len / 2);
      if ($urandom_range(0, 2) == 0) mode = 2'($urandom_range(0, 3));
      cycle(len - len / 2);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
